// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for the forwarding/hazard controller: register tags and
// write enables in, forward selects and stall controls out.
interface hazard_forward_ctrl_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] src_id;
  logic [NUM_SRC-1:0]        src_id_used;
  logic [NUM_SRC*REG_AW-1:0] src_ex;
  logic [REG_AW-1:0]         rd_ex;
  logic                      mem_read_ex;
  logic [REG_AW-1:0]         rd_mem;
  logic                      wr_en_mem;
  logic                      mem_read_mem;
  logic [REG_AW-1:0]         rd_wb;
  logic                      wr_en_wb;
  logic                      flush;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble_ex;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output src_id, src_id_used, src_ex, rd_ex, mem_read_ex, rd_mem, wr_en_mem,
           mem_read_mem, rd_wb, wr_en_wb, flush,
    input  fwd_sel, stall, bubble_ex, stall_cycles
  );

  modport slave (
    input  src_id, src_id_used, src_ex, rd_ex, mem_read_ex, rd_mem, wr_en_mem,
           mem_read_mem, rd_wb, wr_en_wb, flush,
    output fwd_sel, stall, bubble_ex, stall_cycles
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// EX-stage operand forwarding and load-use hazard stall control, with a
// saturating count of stalled cycles.
module hazard_forward_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_ctrl_if.slave bus
);

  typedef enum logic {StIdle, StStall} state_e;

  // Remaining STALL cycles after the first (IDLE) stall cycle.
  localparam logic [2:0] CntInit = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [NUM_SRC*2-1:0] fwd_sel;
  logic             hz;
  logic             stall;

  function automatic logic reg_valid(input logic [REG_AW-1:0] r);
    return (r != '0) || !ZERO_REG;
  endfunction

  always_comb begin
    fwd_sel = '0;
    hz      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [REG_AW-1:0] r_ex;
      logic [REG_AW-1:0] r_id;
      r_ex = bus.src_ex[i*REG_AW +: REG_AW];
      r_id = bus.src_id[i*REG_AW +: REG_AW];
      if (!reset) begin
        // A load in EX/MEM has no data yet, so only MEM/WB can supply it.
        if (bus.wr_en_mem && !bus.mem_read_mem && bus.rd_mem == r_ex && reg_valid(r_ex)) begin
          fwd_sel[2*i +: 2] = 2'b10;
        end else if (bus.wr_en_wb && bus.rd_wb == r_ex && reg_valid(r_ex)) begin
          fwd_sel[2*i +: 2] = 2'b01;
        end
      end
      if (bus.src_id_used[i] && r_id == bus.rd_ex && reg_valid(r_id)) begin
        hz = 1'b1;
      end
    end
    hz = hz & bus.mem_read_ex;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = hz && !bus.flush;
        if (stall && LOAD_LAT > 1) begin
          state_d = StStall;
          cnt_d   = CntInit;
        end
      end
      StStall: begin
        stall = 1'b1;
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.flush) begin
      stall   = 1'b0;
      state_d = StIdle;
    end
    if (reset) begin
      stall = 1'b0;
    end
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= 3'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.fwd_sel      = fwd_sel;
  assign bus.stall        = stall;
  assign bus.bubble_ex    = stall;
  assign bus.stall_cycles = stall_cycles_q;

endmodule
